sha256_msg_schedule: RTL and testbench

Message-schedule stage of the SHA-256 core. It accepts one 512-bit padded block and emits the round words W_0..W_63, one per accepted cycle. It sits directly upstream of the per-round operand muxes and the compression datapath, supplying W_t and the round index t. It also supplies a 2-bit source select that the downstream 4:1 operand mux consumes.

---
 rtl/sha256_msg_schedule.sv | 93 +++++++++
 tb/tb_sha256_msg_schedule.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams W_0..W_{ROUNDS-1}
// using a 16-word sliding window, with round index and operand-mux select alongside.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] block_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   round,
  output logic [1:0]   w_src,
  output logic         done
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its payload stable until that edge.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] window [16];
  logic [5:0]  t;
  logic        load;
  logic        adv;
  logic        last;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        w_valid = 1'b1;
        if (w_ready && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign load  = blk_valid & blk_ready;
  assign adv   = w_valid & w_ready;
  assign last  = (t == LAST_T);
  assign w_new = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // t saturates at the last round so round stays valid through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= '0;
      for (int i = 0; i < 16; i++) window[i] <= '0;
    end else if (load) begin
      t <= '0;
      for (int i = 0; i < 16; i++) window[i] <= block_in[511-32*i -: 32];
    end else if (adv) begin
      if (!last) t <= t + 6'd1;
      for (int i = 0; i < 15; i++) window[i] <= window[i+1];
      window[15] <= w_new;
    end
  end

  assign w_out = window[0];
  assign round = t;
  assign w_src = {1'b0, |t[5:4]};

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: golden recurrence model plus
// hand-computed anchor words, stall, reset-abort and back-to-back scenarios.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] block_in;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [5:0]   round;
  logic [1:0]   w_src;
  logic         done;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .block_in  (block_in),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .round     (round),
    .w_src     (w_src),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_w   [64];
  logic [5:0]  got_r   [64];
  logic [1:0]  got_src [64];
  logic [31:0] ref_w   [64];
  int nw, done_cnt, lat, order_err, stable_err, brdy_err, dv_err, stall_cnt;
  logic done_after, vld_after;
  logic r_valid, r_ready, r_done;
  logic [31:0] r_w;
  logic [5:0]  r_round;
  logic [1:0]  r_src;
  int done_in_rst;

  logic [511:0] abc_blk;
  logic [511:0] ones_blk;
  logic [511:0] b_blk;

  // ---------------- golden model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic void build_exp(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_q.delete();
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endfunction

  // ---------------- drivers / monitor ----------------
  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic present(input logic [511:0] blk, input bit keep, output int waits);
    blk_valid = 1'b1;
    block_in  = blk;
    waits     = 0;
    while (blk_ready !== 1'b1 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout got blk_ready=%b exp=1", blk_ready);
    end
    @(posedge clk);
    #1;
    if (!keep) blk_valid = 1'b0;
  endtask

  task automatic run_words(input bit stall, input int abort_round);
    bit          have_prev;
    bit          finished;
    logic [31:0] pw;
    logic [5:0]  pr;
    logic [1:0]  ps;
    int          cyc;
    nw = 0; done_cnt = 0; lat = -1; order_err = 0; stable_err = 0;
    brdy_err = 0; dv_err = 0; stall_cnt = 0; done_after = 1'bx; vld_after = 1'bx;
    have_prev = 0; finished = 0; cyc = 0;
    while (cyc < 2000 && !finished) begin
      @(negedge clk);
      w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (have_prev && (w_valid !== 1'b1 || w_out !== pw || round !== pr || w_src !== ps))
        stable_err++;
      have_prev = 0;
      if (blk_ready !== 1'b0) brdy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        lat = cyc;
        if (w_valid !== 1'b0) dv_err++;
        finished = 1;
      end else if (w_valid === 1'b1) begin
        if (abort_round >= 0 && int'(round) == abort_round) begin
          rst_n = 1'b0;
          #1;
          r_valid = w_valid; r_ready = blk_ready; r_done = done;
          r_w = w_out; r_round = round; r_src = w_src;
          done_in_rst = 0;
          repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) done_in_rst++;
          end
          rst_n = 1'b1;
          @(negedge clk);
          if (done !== 1'b0) done_in_rst++;
          return;
        end
        if (w_ready) begin
          if (nw < 64) begin
            got_w[nw] = w_out; got_r[nw] = round; got_src[nw] = w_src;
          end
          if (int'(round) != nw) order_err++;
          nw++;
        end else begin
          stall_cnt++;
          have_prev = 1; pw = w_out; pr = round; ps = w_src;
        end
      end
      cyc++;
    end
    if (finished) begin
      @(negedge clk);
      done_after = done;
      vld_after  = w_valid;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; blk_valid = 1'b0; block_in = '0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (blk_ready !== 1'b1) begin failures++; $display("FAIL reset_blk_ready got=%b exp=1", blk_ready); end
    checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_w_valid got=%b exp=0", w_valid); end
    checks++; if (w_out !== 32'h0) begin failures++; $display("FAIL reset_w_out got=%h exp=0", w_out); end
    checks++; if (round !== 6'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round); end
    checks++; if (w_src !== 2'b00) begin failures++; $display("FAIL reset_w_src got=%b exp=00", w_src); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_abc();
    int waits;
    build_exp(abc_blk);
    present(abc_blk, 1'b0, waits);
    run_words(1'b0, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL abc_count got=%0d exp=64", nw); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== exp_q[i]) begin failures++; $display("FAIL abc_w%0d got=%h exp=%h", i, got_w[i], exp_q[i]); end
      ref_w[i] = got_w[i];
    end
    checks++; if (got_w[0] !== 32'h61626380) begin failures++; $display("FAIL abc_hand_w0 got=%h exp=61626380", got_w[0]); end
    checks++; if (got_w[15] !== 32'h00000018) begin failures++; $display("FAIL abc_hand_w15 got=%h exp=00000018", got_w[15]); end
    checks++; if (got_w[16] !== 32'h61626380) begin failures++; $display("FAIL abc_hand_w16 got=%h exp=61626380", got_w[16]); end
    checks++; if (got_w[17] !== 32'h000F0000) begin failures++; $display("FAIL abc_hand_w17 got=%h exp=000f0000", got_w[17]); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL abc_done_count got=%0d exp=1", done_cnt); end
    // 64 word edges after the accepting edge land in DONE: load + 64 words + DONE = 66 cycles.
    checks++; if (lat != 64) begin failures++; $display("FAIL abc_done_latency got=%0d exp=64", lat); end
    checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL abc_done_width got=%b exp=0", done_after); end
    checks++; if (dv_err != 0) begin failures++; $display("FAIL abc_valid_in_done got=%0d exp=0", dv_err); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL abc_round_order got=%0d exp=0", order_err); end
    checks++; if (brdy_err != 0) begin failures++; $display("FAIL abc_blk_ready_busy got=%0d exp=0", brdy_err); end
  endtask

  task automatic test_stall();
    int waits;
    present(abc_blk, 1'b0, waits);
    run_words(1'b1, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL stall_count got=%0d exp=64", nw); end
    checks++; if (stall_cnt == 0) begin failures++; $display("FAIL stall_exercised got=%0d exp=>0", stall_cnt); end
    checks++; if (stable_err != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stable_err); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL stall_round_order got=%0d exp=0", order_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== ref_w[i]) begin failures++; $display("FAIL stall_w%0d got=%h exp=%h", i, got_w[i], ref_w[i]); end
    end
  endtask

  task automatic test_wsrc();
    int waits;
    logic [1:0] es;
    present(abc_blk, 1'b0, waits);
    run_words(1'b0, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL wsrc_count got=%0d exp=64", nw); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      es = (i < 16) ? 2'b00 : 2'b01;
      checks++;
      if (got_src[i] !== es) begin failures++; $display("FAIL wsrc_r%0d got=%b exp=%b", i, got_src[i], es); end
    end
  endtask

  task automatic test_reset_mid_run();
    int waits;
    present(abc_blk, 1'b0, waits);
    run_words(1'b0, 30);
    checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL rst_w_valid got=%b exp=0", r_valid); end
    checks++; if (r_ready !== 1'b1) begin failures++; $display("FAIL rst_blk_ready got=%b exp=1", r_ready); end
    checks++; if (r_w !== 32'h0) begin failures++; $display("FAIL rst_w_out got=%h exp=0", r_w); end
    checks++; if (r_round !== 6'd0) begin failures++; $display("FAIL rst_round got=%0d exp=0", r_round); end
    checks++; if (r_src !== 2'b00) begin failures++; $display("FAIL rst_w_src got=%b exp=00", r_src); end
    checks++; if (r_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", r_done); end
    checks++; if (done_in_rst != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_in_rst); end
    build_exp(abc_blk);
    present(abc_blk, 1'b0, waits);
    run_words(1'b0, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL rst_reload_count got=%0d exp=64", nw); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rst_reload_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== exp_q[i]) begin failures++; $display("FAIL rst_reload_w%0d got=%h exp=%h", i, got_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int waits;
    for (int i = 0; i < 16; i++) b_blk[511-32*i -: 32] = 32'h01234567 ^ (32'(i) * 32'h11111111);
    build_exp(abc_blk);
    present(abc_blk, 1'b1, waits);
    block_in = b_blk;
    run_words(1'b0, -1);
    checks++; if (brdy_err != 0) begin failures++; $display("FAIL b2b_blk_ready_busy got=%0d exp=0", brdy_err); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b_first_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_a_w%0d got=%h exp=%h", i, got_w[i], exp_q[i]); end
    end
    build_exp(b_blk);
    present(b_blk, 1'b0, waits);
    checks++; if (waits != 0) begin failures++; $display("FAIL b2b_first_idle_accept got=%0d exp=0", waits); end
    run_words(1'b0, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL b2b_b_count got=%0d exp=64", nw); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL b2b_second_done got=%0d exp=1", done_cnt); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_b_w%0d got=%h exp=%h", i, got_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_all_ones();
    int waits;
    build_exp(ones_blk);
    present(ones_blk, 1'b0, waits);
    run_words(1'b0, -1);
    checks++; if (nw != 64) begin failures++; $display("FAIL ones_count got=%0d exp=64", nw); end
    // 0x003FFFFF + 0xFFFFFFFF + 0x1FFFFFFF + 0xFFFFFFFF wraps to 0x203FFFFC.
    checks++; if (got_w[16] !== 32'h203FFFFC) begin failures++; $display("FAIL ones_hand_w16 got=%h exp=203ffffc", got_w[16]); end
    for (int i = 0; i < 64 && i < nw; i++) begin
      checks++;
      if (got_w[i] !== exp_q[i]) begin failures++; $display("FAIL ones_w%0d got=%h exp=%h", i, got_w[i], exp_q[i]); end
    end
  endtask

  initial begin
    abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    ones_blk = {512{1'b1}};
    b_blk    = '0;
    test_reset();
    test_abc();
    test_stall();
    test_wsrc();
    test_reset_mid_run();
    test_back_to_back();
    test_all_ones();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
